instruction_fetch_unit: RTL and testbench

Sequences the synchronous `InstructionMemory` for the RISC-V core. It owns the program counter and issues one word read per cycle. It returns each instruction with its PC to decode over a valid/ready handshake, absorbing backpressure in a one-entry hold register. It accepts redirects (branch, jump or trap target) from execute with priority over sequential fetch.

---
 rtl/instruction_fetch_unit_if.sv | 24 ++
 rtl/instruction_fetch_unit.sv | 107 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory read port, redirect input from execute,
// and the valid/ready instruction stream towards decode.
interface instruction_fetch_unit_if;
    logic        im_rd_en;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        fetch_misalign;

    modport master (
        output im_rd_en, im_addr, if_valid, if_pc, if_instr, fetch_misalign,
        input  im_rdata, redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  im_rd_en, im_addr, if_valid, if_pc, if_instr, fetch_misalign,
        output im_rdata, redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, issues one read per cycle to a synchronous
// instruction memory, parks stalled words in a one-entry hold register.
// Optional IF_MISALIGN_CHECK_EN halts fetch on a misaligned redirect.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic clk,
    input  logic rst_n,
    instruction_fetch_unit_if.master bus
);

`ifdef IF_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HOLD = 2'd2, HALT = 2'd3} state_t;
`else
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;
`endif

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] hold_instr;
    logic [31:0] pc_next4;
    logic [31:0] redirect_target;
    logic        redirect_take;
    logic        redirect_bad;
    logic        presenting;

    always_comb begin
        pc_next4   = pc_q + 32'd4;
        presenting = (state == RUN) || (state == HOLD);
`ifdef IF_MISALIGN_CHECK_EN
        redirect_target = bus.redirect_pc;
        redirect_bad    = rst_n && bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
        redirect_take   = rst_n && bus.redirect_valid && (bus.redirect_pc[1:0] == 2'b00);
`else
        redirect_target = bus.redirect_pc & ~32'h0000_0003;
        redirect_bad    = 1'b0;
        redirect_take   = rst_n && bus.redirect_valid;
`endif
    end

    // A redirect (taken or rejected) suppresses the handshake for its cycle.
    always_comb begin
        bus.if_valid       = rst_n && presenting && !bus.redirect_valid;
        bus.if_pc          = pc_q;
        bus.fetch_misalign = redirect_bad;
        bus.im_addr        = (state == BOOT) ? RESET_PC : pc_next4;
        bus.im_rd_en       = 1'b0;
        if (redirect_take) begin
            bus.im_rd_en = 1'b1;
            bus.im_addr  = redirect_target;
        end else if (rst_n && !bus.redirect_valid) begin
            case (state)
                BOOT:      bus.im_rd_en = 1'b1;
                RUN, HOLD: bus.im_rd_en = bus.if_ready;
                default:   bus.im_rd_en = 1'b0;
            endcase
        end
        if (!bus.if_valid)
            bus.if_instr = NOP_INSTR;
        else if (state == HOLD)
            bus.if_instr = hold_instr;
        else
            bus.if_instr = bus.im_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            pc_q  <= 32'h0000_0000;
        end else if (redirect_take) begin
            state <= RUN;
            pc_q  <= redirect_target;
`ifdef IF_MISALIGN_CHECK_EN
        end else if (redirect_bad) begin
            state <= HALT;
`endif
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                    pc_q  <= RESET_PC;
                end
                RUN: begin
                    if (bus.if_ready)
                        pc_q <= pc_next4;
                    else
                        state <= HOLD;
                end
                HOLD: begin
                    if (bus.if_ready) begin
                        state <= RUN;
                        pc_q  <= pc_next4;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    // Memory output is only guaranteed until the next read, so capture it on stall.
    always_ff @(posedge clk) begin
        if (state == RUN && !bus.if_ready && !bus.redirect_valid)
            hold_instr <= bus.im_rdata;
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: vector table, hand-written corner
// sequences and a randomized run against a transaction-level fetch model.
module tb_instruction_fetch_unit;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_0100 + {2'b00, a[31:2]};
    endfunction

    always @(posedge clk) begin
        if (bus.im_rd_en)
            bus.im_rdata <= mem_word(bus.im_addr);
    end

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_rd;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic redir, input logic [31:0] rpc, input logic rdy,
                                input logic e_rd, input logic [31:0] e_addr, input logic e_vld,
                                input logic [31:0] e_pc, input logic [31:0] e_instr);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.rdy = rdy;
        v.e_rd = e_rd; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc; v.e_instr = e_instr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic e_rd, input logic [31:0] e_addr,
                             input logic e_vld, input logic [31:0] e_pc, input logic [31:0] e_instr);
        chk({tag, ".im_rd_en"}, {31'b0, bus.im_rd_en}, {31'b0, e_rd});
        if (e_rd)
            chk({tag, ".im_addr"}, bus.im_addr, e_addr);
        chk({tag, ".if_valid"}, {31'b0, bus.if_valid}, {31'b0, e_vld});
        if (e_vld)
            chk({tag, ".if_pc"}, bus.if_pc, e_pc);
        chk({tag, ".if_instr"}, bus.if_instr, e_instr);
        chk({tag, ".fetch_misalign"}, {31'b0, bus.fetch_misalign}, 32'h0);
    endtask

    task automatic drive(input logic redir, input logic [31:0] rpc, input logic rdy);
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.if_ready       = rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        #1;
        chk("rst.im_rd_en", {31'b0, bus.im_rd_en}, 32'h0);
        chk("rst.im_addr", bus.im_addr, RESET_PC);
        chk("rst.if_valid", {31'b0, bus.if_valid}, 32'h0);
        chk("rst.if_pc", bus.if_pc, 32'h0);
        chk("rst.if_instr", bus.if_instr, NOP_INSTR);
        chk("rst.fetch_misalign", {31'b0, bus.fetch_misalign}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic        m_boot;
    logic [31:0] m_pres;
    logic        r_redir, r_rdy, x_rd, x_vld;
    logic [31:0] r_rpc, x_addr, x_pc, x_instr;

    initial begin
        drive(1'b0, 32'h0, 1'b1);
        vecs[0]  = mk(0, 32'h0,         1, 1, 32'h0,         0, 32'h0,         NOP_INSTR);
        vecs[1]  = mk(0, 32'h0,         1, 1, 32'h4,         1, 32'h0,         32'h100);
        vecs[2]  = mk(0, 32'h0,         1, 1, 32'h8,         1, 32'h4,         32'h101);
        vecs[3]  = mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h8,         32'h102);
        vecs[4]  = mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h8,         32'h102);
        vecs[5]  = mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h8,         32'h102);
        vecs[6]  = mk(0, 32'h0,         1, 1, 32'hC,         1, 32'h8,         32'h102);
        vecs[7]  = mk(0, 32'h0,         1, 1, 32'h10,        1, 32'hC,         32'h103);
        vecs[8]  = mk(1, 32'h40,        1, 1, 32'h40,        0, 32'h0,         NOP_INSTR);
        vecs[9]  = mk(0, 32'h0,         1, 1, 32'h44,        1, 32'h40,        32'h110);
        vecs[10] = mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h44,        32'h111);
        vecs[11] = mk(1, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,         NOP_INSTR);
        vecs[12] = mk(0, 32'h0,         1, 1, 32'h0,         1, 32'hFFFF_FFFC, 32'h4000_00FF);
        vecs[13] = mk(0, 32'h0,         1, 1, 32'h4,         1, 32'h0,         32'h100);

        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_addr,
                      vecs[i].e_vld, vecs[i].e_pc, vecs[i].e_instr);
            @(negedge clk);
        end

        // Asynchronous reset between edges while an instruction is presented.
        drive(1'b0, 32'h0, 1'b1);
        #2;
        chk("async.pre_valid", {31'b0, bus.if_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async.if_valid", {31'b0, bus.if_valid}, 32'h0);
        chk("async.if_instr", bus.if_instr, NOP_INSTR);
        chk("async.im_rd_en", {31'b0, bus.im_rd_en}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_out("async.boot", 1, RESET_PC, 0, 32'h0, NOP_INSTR);
        @(negedge clk);
        #1;
        check_out("async.first", 1, 32'h4, 1, RESET_PC, 32'h100);

        // Randomized run against the transaction-level model.
        do_reset();
        m_boot = 1'b1;
        m_pres = 32'h0;
        for (int n = 0; n < 400; n++) begin
            r_rdy   = ($urandom_range(0, 9) < 7);
            r_redir = ($urandom_range(0, 15) == 0);
            r_rpc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            drive(r_redir, r_rpc, r_rdy);
            x_pc = m_pres;
            x_instr = NOP_INSTR;
            if (r_redir) begin
                x_rd = 1; x_addr = r_rpc; x_vld = 0;
                m_pres = r_rpc; m_boot = 0;
            end else if (m_boot) begin
                x_rd = 1; x_addr = RESET_PC; x_vld = 0;
                m_pres = RESET_PC; m_boot = 0;
            end else begin
                x_vld = 1; x_instr = mem_word(m_pres);
                x_rd = r_rdy; x_addr = m_pres + 32'd4;
                if (r_rdy) m_pres = m_pres + 32'd4;
            end
            #1;
            check_out($sformatf("rnd%0d", n), x_rd, x_addr, x_vld, x_pc, x_instr);
            @(negedge clk);
        end

        // Misaligned redirect to 0x42.
        drive(1'b1, 32'h42, 1'b1);
        #1;
`ifdef IF_MISALIGN_CHECK_EN
        chk("mis.pulse", {31'b0, bus.fetch_misalign}, 32'h1);
        chk("mis.im_rd_en", {31'b0, bus.im_rd_en}, 32'h0);
        chk("mis.if_valid", {31'b0, bus.if_valid}, 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("halt%0d.fetch_misalign", k), {31'b0, bus.fetch_misalign}, 32'h0);
            chk($sformatf("halt%0d.im_rd_en", k), {31'b0, bus.im_rd_en}, 32'h0);
            chk($sformatf("halt%0d.if_valid", k), {31'b0, bus.if_valid}, 32'h0);
            @(negedge clk);
        end
        drive(1'b1, 32'h80, 1'b1);
        #1;
        check_out("resume.redir", 1, 32'h80, 0, 32'h0, NOP_INSTR);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1);
        #1;
        check_out("resume.first", 1, 32'h84, 1, 32'h80, 32'h120);
`else
        check_out("mis.redir", 1, 32'h40, 0, 32'h0, NOP_INSTR);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1);
        #1;
        check_out("mis.first", 1, 32'h44, 1, 32'h40, 32'h110);
`endif
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
